// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer:
// FSM state encoding and the canned control-word patterns per stage.
package pipe_hazard_ctrl_pkg;

  localparam int REG_AW_DEF = 5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_e;

  // One bit per pipeline-register control, MSB first as listed.
  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic id_ex_we;
    logic ex_mem_we;
    logic mem_wb_we;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE     = 8'b0000_0000;
  localparam ctrl_t CTRL_RUN      = 8'b1111_1000;
  localparam ctrl_t CTRL_BRANCH   = 8'b1111_1110;
  localparam ctrl_t CTRL_LOAD_USE = 8'b0011_1010;
  // Freeze lets MEM/WB drain a NOP so a stale writeback is never repeated.
  localparam ctrl_t CTRL_FREEZE   = 8'b0000_1001;

  function automatic ctrl_t run_ctrl(input logic branch_taken, input logic load_use);
    ctrl_t c;
    if (branch_taken) begin
      c = CTRL_BRANCH;
    end else if (load_use) begin
      c = CTRL_LOAD_USE;
    end else begin
      c = CTRL_RUN;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of hazard inputs from the datapath and stage-register controls back to it.
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic              ex_memread;
  logic [REG_AW-1:0] ex_wa;
  logic              branch_taken;
  logic              mem_req;
  logic              mem_ready;

  logic              pc_we;
  logic              if_id_we;
  logic              id_ex_we;
  logic              ex_mem_we;
  logic              mem_wb_we;
  logic              if_id_flush;
  logic              id_ex_flush;
  logic              mem_wb_bubble;
  logic              mem_timeout;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_memread, ex_wa,
           branch_taken, mem_req, mem_ready,
    input  pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
           if_id_flush, id_ex_flush, mem_wb_bubble, mem_timeout, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_memread, ex_wa,
           branch_taken, mem_req, mem_ready,
    output pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
           if_id_flush, id_ex_flush, mem_wb_bubble, mem_timeout, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Pure combinational load-use compare between the ID sources and the load in EX.
module load_use_detect
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_wa,
  output logic              load_use
);

  logic rs_hit_s;
  logic rt_hit_s;

  // Register 0 is hardwired, so a load targeting it never creates a hazard.
  assign rs_hit_s = id_uses_rs && (id_rs == ex_wa);
  assign rt_hit_s = id_uses_rt && (id_rt == ex_wa);
  assign load_use = ex_memread && (ex_wa != {REG_AW{1'b0}}) && (rs_hit_s || rt_hit_s);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: stage-register enables/flushes from hazard inputs,
// memory-wait FSM with timeout, and a saturating stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW       = REG_AW_DEF,
  parameter int MEM_WAIT_MAX = 16,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int                WAIT_W     = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX_C = WAIT_W'(MEM_WAIT_MAX);
  localparam logic [CNT_W-1:0]  CNT_MAX_C  = {CNT_W{1'b1}};

  state_e             state_r;
  logic [WAIT_W-1:0]  wait_cnt_r;
  logic [CNT_W-1:0]   stall_cnt_r;
  logic               mem_timeout_r;
  logic               load_use_s;
  logic               mem_stall_s;
  ctrl_t              ctrl_s;

  load_use_detect #(
    .REG_AW (REG_AW)
  ) u_load_use_detect (
    .id_rs      (bus.id_rs),
    .id_rt      (bus.id_rt),
    .id_uses_rs (bus.id_uses_rs),
    .id_uses_rt (bus.id_uses_rt),
    .ex_memread (bus.ex_memread),
    .ex_wa      (bus.ex_wa),
    .load_use   (load_use_s)
  );

  assign mem_stall_s = bus.mem_req && !bus.mem_ready;

  // Zero-latency control word from current state and hazard inputs.
  always_comb begin
    ctrl_s = CTRL_IDLE;
    if (rst) begin
      ctrl_s = CTRL_IDLE;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (mem_stall_s) begin
            ctrl_s = CTRL_FREEZE;
          end else begin
            ctrl_s = run_ctrl(bus.branch_taken, load_use_s);
          end
        end
        ST_MEM_WAIT: begin
          if (bus.mem_ready) begin
            ctrl_s = run_ctrl(bus.branch_taken, load_use_s);
          end else begin
            ctrl_s = CTRL_FREEZE;
          end
        end
        ST_ERR:  ctrl_s = CTRL_FREEZE;
        default: ctrl_s = CTRL_FREEZE;
      endcase
    end
  end

  // Memory-wait FSM, timeout flag and stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_RUN;
      wait_cnt_r    <= {WAIT_W{1'b0}};
      stall_cnt_r   <= {CNT_W{1'b0}};
      mem_timeout_r <= 1'b0;
    end else begin
      if (!ctrl_s.pc_we && (stall_cnt_r != CNT_MAX_C)) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end
      case (state_r)
        ST_RUN: begin
          if (mem_stall_s) begin
            state_r    <= ST_MEM_WAIT;
            wait_cnt_r <= WAIT_W'(1);
          end
        end
        ST_MEM_WAIT: begin
          if (bus.mem_ready) begin
            state_r    <= ST_RUN;
            wait_cnt_r <= {WAIT_W{1'b0}};
          end else if (wait_cnt_r < WAIT_MAX_C) begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
          end else begin
            state_r       <= ST_ERR;
            mem_timeout_r <= 1'b1;
          end
        end
        ST_ERR: begin
          state_r <= ST_ERR;
        end
        default: begin
          state_r    <= ST_RUN;
          wait_cnt_r <= {WAIT_W{1'b0}};
        end
      endcase
    end
  end

  assign bus.pc_we         = ctrl_s.pc_we;
  assign bus.if_id_we      = ctrl_s.if_id_we;
  assign bus.id_ex_we      = ctrl_s.id_ex_we;
  assign bus.ex_mem_we     = ctrl_s.ex_mem_we;
  assign bus.mem_wb_we     = ctrl_s.mem_wb_we;
  assign bus.if_id_flush   = ctrl_s.if_id_flush;
  assign bus.id_ex_flush   = ctrl_s.id_ex_flush;
  assign bus.mem_wb_bubble = ctrl_s.mem_wb_bubble;
  assign bus.mem_timeout   = mem_timeout_r;
  assign bus.stall_cnt     = stall_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: single-cycle hazard vectors from a table, then hand-written
// memory-wait, timeout and reset sequences.
module tb_pipe_hazard_ctrl;

  localparam logic [7:0] E_RUN    = 8'b1111_1000;
  localparam logic [7:0] E_BRANCH = 8'b1111_1110;
  localparam logic [7:0] E_LU     = 8'b0011_1010;
  localparam logic [7:0] E_FRZ    = 8'b0000_1001;
  localparam logic [7:0] E_ZERO   = 8'b0000_0000;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       memrd;
    logic [4:0] wa;
    logic       br;
    logic       mreq;
    logic       mrdy;
    logic [7:0] exp_ctrl;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_stall = 0;
  logic exp_timeout = 1'b0;
  vec_t vecs [12];

  pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) ifc ();

  pipe_hazard_ctrl #(
    .REG_AW       (5),
    .MEM_WAIT_MAX (4),
    .CNT_W        (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ctrl_word();
    return {ifc.pc_we, ifc.if_id_we, ifc.id_ex_we, ifc.ex_mem_we, ifc.mem_wb_we,
            ifc.if_id_flush, ifc.id_ex_flush, ifc.mem_wb_bubble};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input vec_t v);
    ifc.id_rs        = v.rs;
    ifc.id_rt        = v.rt;
    ifc.id_uses_rs   = v.urs;
    ifc.id_uses_rt   = v.urt;
    ifc.ex_memread   = v.memrd;
    ifc.ex_wa        = v.wa;
    ifc.branch_taken = v.br;
    ifc.mem_req      = v.mreq;
    ifc.mem_ready    = v.mrdy;
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic step_check(input string name, input logic [7:0] exp_ctrl);
    #1;
    check({name, ".ctrl"}, {24'd0, ctrl_word()}, {24'd0, exp_ctrl});
    check({name, ".stall_cnt"}, ifc.stall_cnt, exp_stall);
    check({name, ".timeout"}, {31'd0, ifc.mem_timeout}, {31'd0, exp_timeout});
    @(negedge clk);
    if (!exp_ctrl[7]) exp_stall++;
  endtask

  initial begin
    vec_t z;
    z = '{rs:5'd0, rt:5'd0, urs:1'b0, urt:1'b0, memrd:1'b0, wa:5'd0,
          br:1'b0, mreq:1'b0, mrdy:1'b0, exp_ctrl:E_RUN};
    //            rs     rt     urs   urt   memrd  wa     br    mreq  mrdy  expected
    vecs[0]  = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, E_RUN};
    vecs[1]  = '{5'd8,  5'd0,  1'b1, 1'b0, 1'b1, 5'd8,  1'b0, 1'b0, 1'b0, E_LU};
    vecs[2]  = '{5'd0,  5'd0,  1'b1, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, E_RUN};
    vecs[3]  = '{5'd8,  5'd0,  1'b0, 1'b0, 1'b1, 5'd8,  1'b0, 1'b0, 1'b0, E_RUN};
    vecs[4]  = '{5'd1,  5'd8,  1'b1, 1'b1, 1'b1, 5'd8,  1'b0, 1'b0, 1'b0, E_LU};
    vecs[5]  = '{5'd3,  5'd8,  1'b1, 1'b0, 1'b1, 5'd8,  1'b0, 1'b0, 1'b0, E_RUN};
    vecs[6]  = '{5'd8,  5'd0,  1'b1, 1'b0, 1'b0, 5'd8,  1'b0, 1'b0, 1'b0, E_RUN};
    vecs[7]  = '{5'd8,  5'd0,  1'b1, 1'b0, 1'b1, 5'd8,  1'b1, 1'b0, 1'b0, E_BRANCH};
    vecs[8]  = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, E_BRANCH};
    vecs[9]  = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b1, E_RUN};
    vecs[10] = '{5'd9,  5'd0,  1'b1, 1'b0, 1'b1, 5'd9,  1'b0, 1'b1, 1'b1, E_LU};
    vecs[11] = '{5'd0,  5'd31, 1'b0, 1'b1, 1'b1, 5'd31, 1'b0, 1'b0, 1'b0, E_LU};

    rst = 1'b1;
    set_in(z);
    repeat (2) @(negedge clk);
    check("reset.ctrl", {24'd0, ctrl_word()}, {24'd0, E_ZERO});
    check("reset.stall_cnt", ifc.stall_cnt, 32'd0);
    check("reset.timeout", {31'd0, ifc.mem_timeout}, 32'd0);
    rst = 1'b0;

    // No hazards for ten cycles.
    for (int i = 0; i < 10; i++) step_check("idle", E_RUN);

    for (int i = 0; i < 12; i++) begin
      set_in(vecs[i]);
      step_check($sformatf("vec%0d", i), vecs[i].exp_ctrl);
    end
    set_in(z);
    step_check("after_vecs", E_RUN);

    // Memory busy three cycles, answers on the fourth.
    z.mreq = 1'b1;
    set_in(z);
    for (int i = 0; i < 3; i++) step_check("memwait", E_FRZ);
    z.mrdy = 1'b1;
    set_in(z);
    step_check("mem_release", E_RUN);
    z.mreq = 1'b0; z.mrdy = 1'b0;
    set_in(z);
    step_check("post_release", E_RUN);

    // Release from MEM_WAIT still honours a taken branch that cycle.
    z.mreq = 1'b1;
    set_in(z);
    step_check("mw_br_freeze", E_FRZ);
    z.mrdy = 1'b1; z.br = 1'b1;
    set_in(z);
    step_check("mw_br_release", E_BRANCH);
    z.mreq = 1'b0; z.mrdy = 1'b0; z.br = 1'b0;
    set_in(z);
    step_check("mw_br_after", E_RUN);

    // Memory never answers: five frozen cycles, then stuck in ERR.
    z.mreq = 1'b1;
    set_in(z);
    for (int i = 0; i < 5; i++) step_check("timeout_wait", E_FRZ);
    exp_timeout = 1'b1;
    z.mrdy = 1'b1;
    set_in(z);
    for (int i = 0; i < 3; i++) step_check("err_hold", E_FRZ);
    z.mreq = 1'b0; z.mrdy = 1'b0;
    set_in(z);
    step_check("err_idle", E_FRZ);

    // Asynchronous reset clears everything immediately.
    #2 rst = 1'b1;
    #1;
    check("rst2.ctrl", {24'd0, ctrl_word()}, {24'd0, E_ZERO});
    check("rst2.stall_cnt", ifc.stall_cnt, 32'd0);
    check("rst2.timeout", {31'd0, ifc.mem_timeout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_stall = 0;
    exp_timeout = 1'b0;
    step_check("post_rst", E_RUN);
    vecs[1].mreq = 1'b0;
    set_in(vecs[1]);
    step_check("post_rst_lu", E_LU);
    set_in(z);
    step_check("post_rst_idle", E_RUN);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
